// File: rtl/fp_reduce_pkg.sv
// Shared types and constants for the time-multiplexed FP32 reduction sequencer.
package fp_reduce_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam fp32_t FP32_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_reduce_fifo.sv
// Ring buffer with two write ports (wr0 lands before wr1) and a one- or two-entry pop.
// Exposes the two oldest entries and a registered occupancy count.
module fp_reduce_fifo
  import fp_reduce_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr0_en,
  input  logic [31:0]                wr0_data,
  input  logic                       wr1_en,
  input  logic [31:0]                wr1_data,
  input  logic                       pop1,
  input  logic                       pop2,
  output logic [31:0]                head0,
  output logic [31:0]                head1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  fp32_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr1_ptr;
  logic [PW:0]   n_wr;
  logic [PW:0]   n_rd;

  assign wr1_ptr = wr_ptr + PW'(wr0_en);
  assign n_wr    = (PW+1)'(wr0_en) + (PW+1)'(wr1_en);
  assign n_rd    = pop2 ? (PW+1)'(2) : (PW+1)'(pop1);
  assign head0   = mem[rd_ptr];
  assign head1   = mem[rd_ptr + PW'(1)];

  // NOTE: storage is deliberately left out of reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr_ptr]  <= wr0_data;
    if (wr1_en) mem[wr1_ptr] <= wr1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_wr[PW-1:0];
      rd_ptr <= rd_ptr + n_rd[PW-1:0];
      count  <= count + n_wr - n_rd;
    end
  end

endmodule

// File: rtl/fp_reduce_sequencer.sv
// Sums a frame of NUM_CH FP32 operands through one shared external adder by recirculation.
// Optional FP_REDUCE_RELU_EN clamps a negative final sum to +0.0.
module fp_reduce_sequencer
  import fp_reduce_pkg::*;
#(
  parameter int NUM_CH = 64,
  parameter int DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Data_In,
  input  logic        Valid_In,
  output logic        Ready_In,
  output logic [31:0] Add_A,
  output logic [31:0] Add_B,
  output logic        Add_Valid,
  input  logic [31:0] Add_Result,
  input  logic        Add_Result_Valid,
  output logic [31:0] Data_Out,
  output logic        Valid_Out,
  output logic        Busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_CH + 1);
  localparam logic [CW-1:0] NUM_CH_C = CW'(NUM_CH);
  localparam logic [CW-1:0] LAST_C   = CW'(NUM_CH - 1);
  localparam logic [PW+1:0] OCC_MAX  = (PW+2)'(DEPTH - 2);

  state_t        state, state_nx;
  logic [CW-1:0] in_cnt, res_cnt;
  logic [PW:0]   inflight, count;
  logic [PW+1:0] occ;
  logic          epoch;
  logic          accept, res_take, issue, pop1;
  fp32_t         head0, head1, drain_val;

  // Slots already promised to buffered entries plus outstanding adds must leave room for one more.
  assign occ      = {1'b0, count} + {1'b0, inflight};
  assign Ready_In = (state != ST_DRAIN) && (in_cnt < NUM_CH_C) && (occ <= OCC_MAX);
  assign accept   = Valid_In && Ready_In;
  assign res_take = Add_Result_Valid && epoch && (inflight != '0);

`ifdef FP_REDUCE_RELU_EN
  assign drain_val = head0[31] ? FP32_ZERO : head0;
`else
  assign drain_val = head0;
`endif

  fp_reduce_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr0_en   (res_take),
    .wr0_data (Add_Result),
    .wr1_en   (accept),
    .wr1_data (Data_In),
    .pop1     (pop1),
    .pop2     (issue),
    .head0    (head0),
    .head1    (head1),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    pop1     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_RUN;
      end
      ST_RUN: begin
        issue = (count >= (PW+1)'(2));
        if (in_cnt == NUM_CH_C && res_cnt == LAST_C &&
            count == (PW+1)'(1) && inflight == '0)
          state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        pop1     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt    <= '0;
      res_cnt   <= '0;
      inflight  <= '0;
      epoch     <= 1'b0;
      Add_A     <= FP32_ZERO;
      Add_B     <= FP32_ZERO;
      Add_Valid <= 1'b0;
      Data_Out  <= FP32_ZERO;
      Valid_Out <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Add_Valid <= issue;
      Valid_Out <= 1'b0;
      if (issue) begin
        Add_A <= head0;
        Add_B <= head1;
      end
      if (state == ST_DRAIN) begin
        in_cnt    <= '0;
        res_cnt   <= '0;
        inflight  <= '0;
        epoch     <= 1'b0;
        Busy      <= 1'b0;
        Valid_Out <= 1'b1;
        Data_Out  <= drain_val;
      end else begin
        if (accept) begin
          in_cnt <= in_cnt + CW'(1);
          epoch  <= 1'b1;
          Busy   <= 1'b1;
        end
        if (res_take) res_cnt <= res_cnt + CW'(1);
        inflight <= inflight + (PW+1)'(issue) - (PW+1)'(res_take);
      end
    end
  end

endmodule

// File: tb/tb_fp_reduce_sequencer.sv
// Directed/randomised bench for fp_reduce_sequencer: three instances (NUM_CH 4, 64, 1), each with a 3-cycle behavioural FP adder.
// Expected sums come from exact real-valued addition of the frame operands.
module tb_fp_reduce_sequencer;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  int          sel;

  logic        ready_v [3];
  logic        add_valid_v [3];
  logic        valid_out_v [3];
  logic        busy_v [3];
  logic [31:0] add_a_v [3];
  logic [31:0] add_b_v [3];
  logic [31:0] data_out_v [3];
  logic        pv [3][3];
  logic [31:0] pd [3][3];

  logic        ready, add_valid, valid_out, busy;
  logic [31:0] add_a, add_b, data_out;

  int          n_checks = 0;
  int          n_errors = 0;
  int          add_cnt = 0;
  int          acc_n = 0;
  int          out_cnt = 0;
  logic [31:0] out_vals [32];
  logic        prev_ready = 1'b0;
  logic        mon_occ = 1'b0;
  int          base_acc, base_add;
  logic [31:0] ops_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fp_reduce_sequencer #(.NUM_CH(4), .DEPTH(8)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .Data_In (data_in), .Valid_In (valid_in && sel == 0),
    .Ready_In (ready_v[0]), .Add_A (add_a_v[0]), .Add_B (add_b_v[0]), .Add_Valid (add_valid_v[0]),
    .Add_Result (pd[0][2]), .Add_Result_Valid (pv[0][2]),
    .Data_Out (data_out_v[0]), .Valid_Out (valid_out_v[0]), .Busy (busy_v[0])
  );

  fp_reduce_sequencer #(.NUM_CH(64), .DEPTH(8)) u_dut64 (
    .clk (clk), .rst_n (rst_n), .Data_In (data_in), .Valid_In (valid_in && sel == 1),
    .Ready_In (ready_v[1]), .Add_A (add_a_v[1]), .Add_B (add_b_v[1]), .Add_Valid (add_valid_v[1]),
    .Add_Result (pd[1][2]), .Add_Result_Valid (pv[1][2]),
    .Data_Out (data_out_v[1]), .Valid_Out (valid_out_v[1]), .Busy (busy_v[1])
  );

  fp_reduce_sequencer #(.NUM_CH(1), .DEPTH(8)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .Data_In (data_in), .Valid_In (valid_in && sel == 2),
    .Ready_In (ready_v[2]), .Add_A (add_a_v[2]), .Add_B (add_b_v[2]), .Add_Valid (add_valid_v[2]),
    .Add_Result (pd[2][2]), .Add_Result_Valid (pv[2][2]),
    .Data_Out (data_out_v[2]), .Valid_Out (valid_out_v[2]), .Busy (busy_v[2])
  );

  function automatic real fp2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    if (e > 0) repeat (e) m = m * 2.0;
    else       repeat (-e) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    real a;
    int  e;
    int  m;
    logic s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 8388608.0);
    return {s, 8'(e + 127), 23'(m)};
  endfunction

  function automatic logic [31:0] ref_sum();
    real         s;
    logic [31:0] r;
    s = 0.0;
    foreach (ops_q[i]) s = s + fp2r(ops_q[i]);
    r = r2fp(s);
`ifdef FP_REDUCE_RELU_EN
    if (r[31]) r = 32'h0;
`endif
    return r;
  endfunction

  // Behavioural FP adder, 3-cycle latency, not affected by the sequencer reset.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      pv[g][0] <= add_valid_v[g];
      pd[g][0] <= add_valid_v[g] ? r2fp(fp2r(add_a_v[g]) + fp2r(add_b_v[g])) : 32'h0;
      pv[g][1] <= pv[g][0];
      pd[g][1] <= pd[g][0];
      pv[g][2] <= pv[g][1];
      pd[g][2] <= pd[g][1];
    end
  end

  always_comb begin
    ready     = ready_v[sel];
    add_valid = add_valid_v[sel];
    valid_out = valid_out_v[sel];
    busy      = busy_v[sel];
    add_a     = add_a_v[sel];
    add_b     = add_b_v[sel];
    data_out  = data_out_v[sel];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (add_valid) add_cnt <= add_cnt + 1;
      if (mon_occ)
        check("occupancy_ready", 32'(ready &&
              ((acc_n - base_acc) - (add_cnt + int'(add_valid) - base_add) > 6)), 32'd0);
      if (valid_in && ready) acc_n <= acc_n + 1;
      if (valid_out) begin
        out_vals[out_cnt % 32] <= data_out;
        out_cnt <= out_cnt + 1;
        check("ready_low_in_drain", 32'(prev_ready), 32'd0);
        check("ready_after_drain", 32'(ready), 32'd1);
        check("busy_at_out", 32'(busy), 32'd0);
      end
      prev_ready <= ready;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_add_valid"}, 32'(add_valid), 32'd0);
    check({tag, "_add_a"}, add_a, 32'h0);
    check({tag, "_add_b"}, add_b, 32'h0);
    check({tag, "_data_out"}, data_out, 32'h0);
    check({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic send(input logic [31:0] v);
    int   t;
    logic acc;
    t        = 0;
    acc      = 1'b0;
    data_in  = v;
    valid_in = 1'b1;
    while (!acc && t < 300) begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      t++;
    end
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_cnt < n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("out_wait", 32'(out_cnt >= n), 32'd1);
  endtask

  task automatic set4(input logic [31:0] a, b, c, d);
    ops_q.delete();
    ops_q.push_back(a);
    ops_q.push_back(b);
    ops_q.push_back(c);
    ops_q.push_back(d);
  endtask

  task automatic run_frame(input int inst, input int gaps, input string tag);
    int b_add, b_out;
    sel   = inst;
    b_add = add_cnt;
    b_out = out_cnt;
    foreach (ops_q[i]) begin
      if (gaps > 0) begin
        valid_in = 1'b0;
        repeat ($urandom_range(0, gaps)) @(posedge clk);
        #1;
      end
      send(ops_q[i]);
      if (i == 0) check({tag, "_busy"}, 32'(busy), 32'd1);
    end
    valid_in = 1'b0;
    wait_out(b_out + 1);
    check({tag, "_sum"}, out_vals[b_out % 32], ref_sum());
    check({tag, "_adds"}, add_cnt - b_add, ops_q.size() - 1);
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_one_out"}, out_cnt - b_out, 1);
    check({tag, "_hold"}, data_out, out_vals[b_out % 32]);
  endtask

  initial begin : main
    int          b_add, b_out, t;
    logic [31:0] e0, e1;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;
    sel      = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four operands back-to-back: 10.0 with three adds.
    set4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    run_frame(0, 0, "t1");
    check("t1_spec_value", out_vals[(out_cnt - 1) % 32], 32'h41200000);

    // 64 x 1.0 with random gaps, occupancy-based backpressure watched.
    ops_q.delete();
    repeat (64) ops_q.push_back(32'h3F800000);
    sel      = 1;
    base_acc = acc_n;
    base_add = add_cnt;
    mon_occ  = 1'b1;
    run_frame(1, 3, "t2");
    mon_occ  = 1'b0;

    // Two frames streamed with Valid_In held high.
    sel   = 0;
    b_add = add_cnt;
    b_out = out_cnt;
    for (int k = 1; k <= 8; k++) send(r2fp(real'(k)));
    valid_in = 1'b0;
    set4(r2fp(1.0), r2fp(2.0), r2fp(3.0), r2fp(4.0));
    e0 = ref_sum();
    set4(r2fp(5.0), r2fp(6.0), r2fp(7.0), r2fp(8.0));
    e1 = ref_sum();
    wait_out(b_out + 2);
    check("t3_frame0", out_vals[b_out % 32], e0);
    check("t3_frame1", out_vals[(b_out + 1) % 32], e1);
    check("t3_adds", add_cnt - b_add, 6);

    // Single-operand frame: passes straight through.
    ops_q.delete();
    ops_q.push_back(32'hC0400000);
    run_frame(2, 0, "t4");

    // Mixed signs: -2.0 (clamped with the ReLU option).
    set4(32'hBF800000, 32'hC0000000, 32'h3F000000, 32'h3F000000);
    run_frame(0, 1, "t5");

    // Reset mid-frame with an add in flight, then a clean frame.
    sel   = 0;
    b_add = add_cnt;
    b_out = out_cnt;
    send(32'h3F800000);
    send(32'h40000000);
    valid_in = 1'b0;
    t = 0;
    while (add_cnt == b_add && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("t6_issue_seen", add_cnt - b_add, 1);
    rst_n = 1'b0;
    #1;
    check_idle("t6_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_out", out_cnt - b_out, 0);
    check("t6_idle_busy", 32'(busy), 32'd0);
    set4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    run_frame(0, 0, "t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed still running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_reduce_sequencer.md
# fp_reduce_sequencer

Time-multiplexed reduction controller that sums a frame of `NUM_CH` FP32 partial results using one shared `FP_Adder`. It replaces a full adder tree such as the 64-input reducer when area matters. It sits between a channel-result producer and the accumulation/activation stage. It accepts operands over a valid/ready stream, pairs them into the external adder, recirculates adder results until one value remains, then emits it.

## Interface
Parameters:
- `NUM_CH`, 64: operands per frame (≥1)
- `DEPTH`, 8: operand buffer entries (≥4, power of two)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `Data_In`  in  32  FP32 operand
- `Valid_In`  in  1  operand valid
- `Ready_In`  out  1  operand accepted when `Valid_In && Ready_In`
- `Add_A`, `Add_B`  out  32  operands to `FP_Adder` (`Mode`=0 and `RMode`=0 are tied off at the instantiating level)
- `Add_Valid`  out  1  issue strobe to `FP_Adder.Valid_In`
- `Add_Result`  in  32  `FP_Adder.Data_Out`
- `Add_Result_Valid`  in  1  `FP_Adder.Valid_Out`
- `Data_Out`  out  32  frame sum
- `Valid_Out`  out  1  one-cycle pulse with `Data_Out`
- `Busy`  out  1  high from first accepted operand until `Valid_Out`

## Operation
- Buffer: `DEPTH`-entry FIFO with 2 write ports and 2 read ports. In one cycle it accepts one adder result plus one input operand; the result is written first.
- Counters:
  - `in_cnt` counts accepted operands, 0..`NUM_CH`.
  - `inflight` counts adds issued but not yet returned, 0..`DEPTH`/2.
  - `res_cnt` counts adder results returned, 0..`NUM_CH`-1.
- `Ready_In` = `in_cnt < NUM_CH` && (`count + inflight` ≤ `DEPTH`-2). Reservation guarantees no overflow; the adder result is never dropped or stalled.
- Issue: when the registered FIFO count ≥2 at the start of a cycle, pop the two head entries. Drive `Add_A` = older and `Add_B` = newer, with `Add_Valid`=1 registered next cycle. `inflight` is incremented. At most one issue per cycle.
- FSM states:
  - IDLE → RUN on the first accepted operand.
  - RUN → DRAIN when `in_cnt==NUM_CH` && `res_cnt==NUM_CH-1` && `count==1` && `inflight==0`.
  - DRAIN pops the last entry into `Data_Out` and pulses `Valid_Out`, then → IDLE. All counters clear.
- `NUM_CH`=1: the single operand passes to `Data_Out` with no adder issue.
- An adder result arriving while an issue pops the FIFO is legal; count updates net of +2 writes and −2 reads.
- Input for the next frame is not accepted during DRAIN (`Ready_In`=0). It is accepted from the following IDLE cycle.
- Summation order is not a balanced tree. FP results equal tree results only for exactly representable sums.

## Timing
- Reset values:
  - `Ready_In`=1, `Add_Valid`=0, `Add_A`=`Add_B`=0.
  - `Data_Out`=0, `Valid_Out`=0, `Busy`=0.
  - FSM IDLE, FIFO empty, all counters 0.
- `rst_n` asserted mid-frame aborts immediately. Buffered operands and counts are discarded, and adder results returning later are ignored until the next accepted operand. Use an epoch flag cleared by reset; ignored results are not counted.
- Latency is ≥ ceil(log2 `NUM_CH`)·(adder latency + 1) + 2 cycles after the last operand.
- `Data_Out` holds until the next `Valid_Out`.

## Configuration
- `FP_REDUCE_RELU_EN` defined: in DRAIN, if bit 31 of the final sum is 1, `Data_Out` = 32'h0. Otherwise the sum passes unchanged.
- Undefined: the raw sum is always output.

## Structure
- Shared package `fp_reduce_pkg`:
  - `fp32_t` typedef.
  - FSM state enum.
  - `FP32_ZERO` constant.
- One sub-module `fp_reduce_fifo`: 2W/2R ring buffer with count, parameterised by `DEPTH`.
- `FP_Adder` is instantiated outside this block.

## Test plan
The bench uses a behavioural FP adder with 3-cycle latency.
- `NUM_CH`=4, operands 1.0, 2.0, 3.0, 4.0 back-to-back → one `Valid_Out` with `Data_Out`=32'h41200000; exactly 3 `Add_Valid` pulses.
- `NUM_CH`=64, all operands 1.0, random `Valid_In` gaps → `Data_Out`=32'h42800000; `Ready_In` deasserts whenever count+inflight >6; no overflow assertion fires.
- Two frames of `NUM_CH`=4 streamed with `Valid_In` held high → 10.0, then 26.0 for 5.0..8.0; no `Ready_In` during DRAIN.
- `NUM_CH`=1, operand 32'hC0400000 → `Data_Out`=32'hC0400000 (32'h0 with `FP_REDUCE_RELU_EN`); no `Add_Valid`.
- `NUM_CH`=4, operands −1.0, −2.0, 0.5, 0.5 → 32'hC0000000 without the macro, 32'h0 with it.
- Reset asserted after 2 of 4 operands with one add in flight, then a fresh frame 1.0..4.0 → `Data_Out`=10.0; the stale result is ignored.
